// File: rtl/prog_clock_divider_pkg.sv
// Shared types and constants for the programmable clock divider.
package prog_clock_divider_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 2;

   // Number of counts per period during which the phase flop is high: ceil(n/2).
   function automatic int unsigned high_len(input int unsigned n);
      return (n >> 1) + (n & 32'd1);
   endfunction

endpackage

// File: rtl/div_load_ctrl.sv
// Divisor load handshake: validates requests, holds the pending divisor and
// swaps it into div_active when the top signals a legal apply window.
module div_load_ctrl
   import prog_clock_divider_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV_RESET = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   input  logic             apply_window,
   output logic             accept_c,
   output logic             apply_c,
   output logic [WIDTH-1:0] div_active,
   output logic             div_ack,
   output logic             div_err
);

   logic             pend_valid;
   logic [WIDTH-1:0] pend_div;

   always_comb begin
      accept_c = div_load && (div_in >= WIDTH'(MIN_DIV));
      apply_c  = pend_valid && apply_window;
   end

   // A load sampled in the apply cycle itself only becomes pending, so it
   // waits for the following window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_div   <= '0;
         div_active <= WIDTH'(DIV_RESET);
         div_ack    <= 1'b0;
         div_err    <= 1'b0;
      end else begin
         div_ack <= apply_c;
         if (apply_c) begin
            div_active <= pend_div;
         end
         if (accept_c) begin
            pend_div   <= div_in;
            pend_valid <= 1'b1;
         end else if (apply_c) begin
            pend_valid <= 1'b0;
         end
         if (accept_c) begin
            div_err <= 1'b0;
         end else if (div_load) begin
            div_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable 50%-duty integer clock divider with glitch-free divisor change.
// Define ODD_DUTY50_EN to add a negedge phase flop giving exact 50% duty for odd N.
module prog_clock_divider
   import prog_clock_divider_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV_RESET = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic [WIDTH-1:0] div_active,
   output logic [WIDTH-1:0] count,
   output logic             clk_out,
   output logic             tick
);

   state_t           state_q;
   state_t           state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] last_c;
   logic [WIDTH-1:0] half_len_c;
   logic             wrap_c;
   logic             apply_window_c;
   logic             accept_c;
   logic             apply_c;
   logic             pos_n;
   logic             pos_q;

   div_load_ctrl #(
      .WIDTH     (WIDTH),
      .DIV_RESET (DIV_RESET)
   ) u_div_load_ctrl (
      .clk          (clk),
      .reset        (reset),
      .div_in       (div_in),
      .div_load     (div_load),
      .apply_window (apply_window_c),
      .accept_c     (accept_c),
      .apply_c      (apply_c),
      .div_active   (div_active),
      .div_ack      (div_ack),
      .div_err      (div_err)
   );

   // Period boundary detection and next counter / phase values.
   always_comb begin
      last_c         = div_active - WIDTH'(1);
      half_len_c     = WIDTH'(high_len(32'(div_active)));
      wrap_c         = en && (state_q != STOP) && (count == last_c);
      apply_window_c = (state_q == STOP) || wrap_c;
      count_n        = '0;
      if (en && (state_q != STOP) && !wrap_c) begin
         count_n = count + WIDTH'(1);
      end
      pos_n = en && (count_n < half_len_c);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= STOP;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         STOP:    if (en) state_n = accept_c ? PEND : RUN;
         RUN:     if (accept_c) state_n = PEND;
         PEND:    if (apply_c && !accept_c) state_n = RUN;
         default: state_n = STOP;
      endcase
      if (!en) begin
         state_n = STOP;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         pos_q <= 1'b0;
         tick  <= 1'b0;
      end else begin
         count <= count_n;
         pos_q <= pos_n;
         tick  <= en && (count_n == '0);
      end
   end

`ifdef ODD_DUTY50_EN
   logic neg_q;

   // Half-cycle delayed phase trims the odd-N high time by half a clock.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= pos_q;
      end
   end

   assign clk_out = div_active[0] ? (pos_q & neg_q) : pos_q;
`else
   assign clk_out = pos_q;
`endif

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Parametrised integer clock divider producing a 50%-duty output for both even and odd divisors, with a runtime divisor-change handshake. A new divisor is applied only at a period boundary, so the output never glitches. The block sits in the clocking path and generates derived clocks and period ticks for downstream logic. It is the next generation of the fixed-width pos/neg-edge-count divider.

## Interface
Parameters:
- WIDTH, 8: width of divisor and counter.
- DIV_RESET, 2: divisor in force after reset; must be ≥2.

Ports:
- clk  in  1  input clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable. When low, the counter holds at 0 and clk_out is low.
- div_in  in  WIDTH  requested divisor N.
- div_load  in  1  one-cycle request to adopt div_in.
- div_ack  out  1  one-cycle pulse in the first cycle that runs with the new divisor.
- div_err  out  1  sticky flag: last load was rejected (N<2).
- div_active  out  WIDTH  divisor currently in force.
- count  out  WIDTH  posedge counter, range 0..N-1.
- clk_out  out  1  divided clock.
- tick  out  1  one-cycle pulse when count==0 and en=1.

## Operation
- State machine: STOP, RUN, PEND.
  - STOP → RUN when en=1.
  - RUN → PEND when a valid load is accepted.
  - PEND → RUN when the divisor is applied.
  - Any state → STOP when en=0. A pending request in PEND is kept and applied on the next cycle.
- Counter:
  - On each posedge with en=1: count = (count==N-1) ? 0 : count+1.
  - With en=0: count=0.
- Phase signal pos_q is registered from the next count value: pos_q = (count_next < H).
  - Even N: H = N/2.
  - Odd N: H = (N+1)/2.
- Duty for odd N is set by ODD_DUTY50_EN (see Configuration). Even N: clk_out = pos_q.
- Load handling:
  - div_load with div_in ≥ 2: accepted and held pending; a later load before apply replaces it (last wins).
  - div_load with div_in < 2: rejected, div_err=1, pending request unchanged.
  - div_err clears on the next accepted load.
- Apply:
  - In RUN/PEND, a pending divisor loads at the posedge where count wraps N-1→0. That cycle has count=0, div_active=new N, div_ack=1, tick=1.
  - In STOP, a pending divisor applies at the next posedge and div_ack pulses.
- Simultaneous div_load and wrap in the same cycle: the new request is not applied at this wrap. It waits for the following wrap.
- Widths: all counter compares are unsigned WIDTH-bit. N = 2^WIDTH−1 is supported.

## Timing
- Reset values: count=0, div_active=DIV_RESET, clk_out=0, tick=0, div_ack=0, div_err=0, state STOP, no pending request.
- Reset asserted mid-operation clears all state asynchronously, including any pending load. clk_out falls immediately.
- From en rising (sampled at posedge k): count=0 and tick=1 after posedge k; clk_out rises at posedge k.
- div_load to div_ack latency: from 1 cycle up to N_old+1 cycles.
- Output period is N clk cycles. clk_out rises only on a posedge of clk.
- en low mid-period: at the next posedge, count=0 and clk_out=0 (truncated period allowed).

## Configuration
- ODD_DUTY50_EN defined:
  - A negedge flop neg_q captures pos_q.
  - For odd N, clk_out = pos_q & neg_q, giving high time N/2 clk periods (exact 50%).
  - neg_q resets to 0.
- ODD_DUTY50_EN undefined:
  - No negedge logic; clk_out = pos_q for all N.
  - For odd N, high time is (N+1)/2 cycles.

## Structure
- Package prog_clock_divider_pkg holds:
  - the state enum (STOP, RUN, PEND);
  - the constant MIN_DIV = 2.
- One sub-module, div_load_ctrl, owns:
  - pending register, validation, div_err, div_ack generation.
- The top level holds the counter, phase flops and output logic.

## Test plan
- Reset, then en=1 with DIV_RESET=2 and a 10 ns clk → clk_out period 20 ns, high 10 ns; tick every 2 cycles.
- Load N=5 with ODD_DUTY50_EN defined → after div_ack, clk_out period 50 ns, high exactly 25 ns, count cycles 0..4.
- Same as above with the macro undefined → period 50 ns, high 30 ns.
- Load N=8 at count=1 under N=5, then N=3 one cycle later → only N=3 applied at the next wrap; one div_ack; div_active=3.
- Load N=1 → div_err=1, div_active unchanged, no div_ack. A following load of N=4 clears div_err.
- Assert reset mid-period while a load is pending → all outputs at reset values, no div_ack after release, div_active=DIV_RESET.
